seq_mul_unit: RTL

- Multi-cycle RV32M multiplier sitting directly downstream of the ALU operand stage, where the XOR bus supplies operand sign/inversion.
- Accepts MUL/MULH/MULHSU/MULHU requests and iterates a radix-2 shift-add over unsigned magnitudes, one bit per cycle.
- Applies sign correction from signA XOR signB.
- Returns an N-bit result with a one-cycle Done pulse; the CPU control stalls on Busy.

---
 rtl/seq_mul_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-2 shift-add over magnitudes
module seq_mul_unit #(
    parameter int NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [1:0]          Op,
    input  logic [NrOfBits-1:0] Operand_A,
    input  logic [NrOfBits-1:0] Operand_B,
    output logic [NrOfBits-1:0] Result,
    output logic                Done,
    output logic                Busy
);
    localparam int N  = NrOfBits;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [2*N-1:0]  acc;
    logic [N-1:0]    mcand;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic            is_mul;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;
    logic [N:0]      sum;
    logic [2*N-1:0]  prod;

    assign a_signed = (Op == 2'b01) || (Op == 2'b10);
    assign b_signed = (Op == 2'b01);
    assign a_neg    = a_signed && Operand_A[N-1];
    assign b_neg    = b_signed && Operand_B[N-1];
    assign a_mag    = a_neg ? (~Operand_A + 1'b1) : Operand_A;
    assign b_mag    = b_neg ? (~Operand_B + 1'b1) : Operand_B;
    // upper half plus optional multiplicand; the carry becomes the new MSB after the shift
    assign sum      = {1'b0, acc[2*N-1:N]} + {1'b0, acc[0] ? mcand : {N{1'b0}}};
    assign prod     = neg ? (~acc + 1'b1) : acc;

    // state register
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state: fixed NrOfBits iterations, one fix-up cycle, one done cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Start ? RUN : IDLE;
            RUN:     state_nxt = (cnt == CW'(1)) ? FIX : RUN;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from the registered state
    always_comb begin
        Busy = (state == RUN) || (state == FIX);
        Done = (state == DONE);
    end

    // datapath: multiplier lives in the low half of the accumulator and shifts out as the product shifts in
    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc    <= '0;
            mcand  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            is_mul <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    acc    <= {{N{1'b0}}, b_mag};
                    mcand  <= a_mag;
                    cnt    <= CW'(N);
                    neg    <= a_neg ^ b_neg;
                    is_mul <= (Op == 2'b00);
                end
                RUN: begin
                    acc <= {sum, acc[N-1:1]};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    acc    <= prod;
                    Result <= is_mul ? prod[N-1:0] : prod[2*N-1:N];
                end
                default: ;
            endcase
        end
    end
endmodule
